// File: rtl/rob_flush.sv
// Parametrised reorder buffer: in-order allocate and retire, NWB writeback channels, two bypassed
// operand lookups, and a full flush with fetch redirect when a mispredicted branch retires.
module rob_flush #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned NWB    = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                alloc_valid,
  input  logic                alloc_done,
  input  logic [REG_W-1:0]    alloc_dest,
  input  logic                alloc_is_mem,
  input  logic                alloc_is_br,
  output logic [TAG_W-1:0]    alloc_tag,
  output logic                full,
  output logic [TAG_W:0]      count,
  input  logic [NWB-1:0]      wb_valid,
  input  logic [NWB*TAG_W-1:0]  wb_tag,
  input  logic [NWB*DATA_W-1:0] wb_data,
  input  logic [NWB-1:0]      wb_mispredict,
  input  logic [NWB*32-1:0]   wb_target,
  input  logic                q1_valid,
  input  logic [TAG_W-1:0]    q1_tag,
  output logic                q1_hit,
  output logic [DATA_W-1:0]   q1_data,
  input  logic                q2_valid,
  input  logic [TAG_W-1:0]    q2_tag,
  output logic                q2_hit,
  output logic [DATA_W-1:0]   q2_data,
  output logic                mem_head_valid,
  output logic [TAG_W-1:0]    mem_head_tag,
  output logic                commit_valid,
  output logic [REG_W-1:0]    commit_dest,
  output logic [TAG_W-1:0]    commit_tag,
  output logic [DATA_W-1:0]   commit_data,
  output logic                flush,
  output logic [31:0]         redirect_pc
);

  logic [TAG_W-1:0]  head, tail;
  logic [DEPTH-1:0]  occ, rdy_e, mem_e, br_e, mis_e;
  logic [REG_W-1:0]  dest_e   [DEPTH];
  logic [DATA_W-1:0] data_e   [DEPTH];
  logic [31:0]       target_e [DEPTH];
  logic              do_alloc, do_commit, flushing;

  assign alloc_tag      = tail;
  assign full           = (count == (TAG_W+1)'(DEPTH));
  assign do_alloc       = alloc_valid & ~full;
  assign do_commit      = (count != '0) & occ[head] & rdy_e[head];
  assign flushing       = do_commit & mis_e[head];
  assign mem_head_valid = occ[head] & mem_e[head];
  assign mem_head_tag   = head;

  // Stored result first, then the lowest-index writeback on the same tag.
  function automatic logic [DATA_W:0] lookup(input logic valid, input logic [TAG_W-1:0] t);
    logic [DATA_W:0] r;
    r = '0;
    if (valid) begin
      if (occ[t] && rdy_e[t]) begin
        r = {1'b1, data_e[t]};
      end else begin
        for (int i = int'(NWB) - 1; i >= 0; i--) begin
          if (wb_valid[i] && (wb_tag[i*TAG_W +: TAG_W] == t)) begin
            r = {1'b1, wb_data[i*DATA_W +: DATA_W]};
          end
        end
      end
    end
    return r;
  endfunction

  assign {q1_hit, q1_data} = lookup(q1_valid, q1_tag);
  assign {q2_hit, q2_data} = lookup(q2_valid, q2_tag);

  // Payload is gated by occupancy everywhere it is read, so it needs no reset.
  always_ff @(posedge clk) begin
    if (rdy && !flushing) begin
      for (int i = int'(NWB) - 1; i >= 0; i--) begin
        if (wb_valid[i] && occ[wb_tag[i*TAG_W +: TAG_W]]) begin
          data_e[wb_tag[i*TAG_W +: TAG_W]]   <= wb_data[i*DATA_W +: DATA_W];
          target_e[wb_tag[i*TAG_W +: TAG_W]] <= wb_target[i*32 +: 32];
          // Only branch entries can redirect fetch.
          mis_e[wb_tag[i*TAG_W +: TAG_W]]    <= wb_mispredict[i] & br_e[wb_tag[i*TAG_W +: TAG_W]];
        end
      end
      if (do_alloc) begin
        dest_e[tail] <= alloc_dest;
        mem_e[tail]  <= alloc_is_mem;
        br_e[tail]   <= alloc_is_br;
        mis_e[tail]  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      occ          <= '0;
      rdy_e        <= '0;
      commit_valid <= 1'b0;
      commit_dest  <= '0;
      commit_tag   <= '0;
      commit_data  <= '0;
      flush        <= 1'b0;
      redirect_pc  <= '0;
    end else if (rdy) begin
      commit_valid <= 1'b0;
      flush        <= 1'b0;
      if (do_commit) begin
        commit_valid <= (dest_e[head] != '0);
        commit_dest  <= dest_e[head];
        commit_tag   <= head;
        commit_data  <= data_e[head];
      end
      if (flushing) begin
        flush       <= 1'b1;
        redirect_pc <= target_e[head];
        head        <= '0;
        tail        <= '0;
        count       <= '0;
        occ         <= '0;
        rdy_e       <= '0;
      end else begin
        for (int i = int'(NWB) - 1; i >= 0; i--) begin
          if (wb_valid[i] && occ[wb_tag[i*TAG_W +: TAG_W]]) begin
            rdy_e[wb_tag[i*TAG_W +: TAG_W]] <= 1'b1;
          end
        end
        if (do_alloc) begin
          occ[tail]   <= 1'b1;
          rdy_e[tail] <= alloc_done;
        end
        if (do_commit) begin
          occ[head] <= 1'b0;
          head      <= head + TAG_W'(1);
        end
        tail  <= tail + TAG_W'(do_alloc);
        count <= count + (TAG_W+1)'(do_alloc) - (TAG_W+1)'(do_commit);
      end
    end
  end

endmodule

// File: tb/tb_rob_flush.sv
// Directed bench for rob_flush: allocation/wrap, in-order retire, writeback priority and bypass,
// mispredict flush, rdy freeze and asynchronous reset.
module tb_rob_flush;
  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        alloc_valid, alloc_done, alloc_is_mem, alloc_is_br;
  logic [4:0]  alloc_dest;
  logic [3:0]  alloc_tag;
  logic        full;
  logic [4:0]  count;
  logic [2:0]  wb_valid, wb_mispredict;
  logic [11:0] wb_tag;
  logic [95:0] wb_data, wb_target;
  logic        q1_valid, q2_valid, q1_hit, q2_hit;
  logic [3:0]  q1_tag, q2_tag;
  logic [31:0] q1_data, q2_data;
  logic        mem_head_valid;
  logic [3:0]  mem_head_tag;
  logic        commit_valid;
  logic [4:0]  commit_dest;
  logic [3:0]  commit_tag;
  logic [31:0] commit_data;
  logic        flush;
  logic [31:0] redirect_pc;

  int total = 0;
  int passes = 0;

  rob_flush dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .alloc_valid(alloc_valid), .alloc_done(alloc_done), .alloc_dest(alloc_dest),
    .alloc_is_mem(alloc_is_mem), .alloc_is_br(alloc_is_br), .alloc_tag(alloc_tag),
    .full(full), .count(count),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
    .wb_mispredict(wb_mispredict), .wb_target(wb_target),
    .q1_valid(q1_valid), .q1_tag(q1_tag), .q1_hit(q1_hit), .q1_data(q1_data),
    .q2_valid(q2_valid), .q2_tag(q2_tag), .q2_hit(q2_hit), .q2_data(q2_data),
    .mem_head_valid(mem_head_valid), .mem_head_tag(mem_head_tag),
    .commit_valid(commit_valid), .commit_dest(commit_dest), .commit_tag(commit_tag),
    .commit_data(commit_data), .flush(flush), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    alloc_valid = 0; alloc_done = 0; alloc_dest = 0; alloc_is_mem = 0; alloc_is_br = 0;
    wb_valid = 0; wb_tag = 0; wb_data = 0; wb_mispredict = 0; wb_target = 0;
    q1_valid = 0; q2_valid = 0; q1_tag = 0; q2_tag = 0;
  endtask

  task automatic alloc(input logic [4:0] d, input logic done, input logic mem, input logic br);
    alloc_valid = 1; alloc_dest = d; alloc_done = done; alloc_is_mem = mem; alloc_is_br = br;
    tick();
    alloc_valid = 0; alloc_dest = 0; alloc_done = 0; alloc_is_mem = 0; alloc_is_br = 0;
  endtask

  task automatic wb(input int ch, input logic [3:0] t, input logic [31:0] d, input logic mp,
                    input logic [31:0] tgt);
    wb_valid[ch] = 1'b1;
    wb_tag[ch*4 +: 4] = t;
    wb_data[ch*32 +: 32] = d;
    wb_mispredict[ch] = mp;
    wb_target[ch*32 +: 32] = tgt;
  endtask

  task automatic do_reset();
    clr();
    rdy = 1;
    rst = 1;
    tick();
    rst = 0;
  endtask

  initial begin
    clr();
    rdy = 1;
    rst = 1;
    #2;
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_alloc_tag", alloc_tag, 0);
    chk("rst_commit_valid", commit_valid, 0);
    chk("rst_flush", flush, 0);
    chk("rst_redirect", redirect_pc, 0);
    tick();
    rst = 0;

    // Fill, overflow, commit while full, wrap
    for (int i = 0; i < 16; i++) begin
      alloc_valid = 1; alloc_dest = 5'(i + 1);
      #1;
      chk("fill_tag", alloc_tag, 64'(i));
      tick();
      clr();
    end
    chk("fill_count", count, 16);
    chk("fill_full", full, 1);
    alloc(5'd31, 0, 0, 0);
    chk("overflow_count", count, 16);
    chk("overflow_tail", alloc_tag, 0);
    wb(0, 4'd0, 32'hAA, 0, 0);
    tick();
    clr();
    chk("no_wb_bypass", commit_valid, 0);
    alloc(5'd30, 0, 0, 0);  // full at start of cycle: dropped even though head retires
    chk("full_commit_valid", commit_valid, 1);
    chk("full_commit_tag", commit_tag, 0);
    chk("full_commit_data", commit_data, 32'hAA);
    chk("full_commit_dest", commit_dest, 1);
    chk("full_commit_count", count, 15);
    chk("wrap_alloc_tag", alloc_tag, 0);
    alloc(5'd20, 0, 0, 0);
    chk("wrap_count", count, 16);
    chk("wrap_no_commit", commit_valid, 0);

    // In-order retire
    do_reset();
    alloc(5'd5, 0, 0, 0);
    alloc(5'd6, 0, 0, 0);
    alloc(5'd7, 0, 0, 0);
    chk("io_count3", count, 3);
    wb(0, 4'd2, 32'h22, 0, 0);
    tick();
    clr();
    chk("io_young_ready_no_commit", commit_valid, 0);
    q1_valid = 1; q1_tag = 4'd2; q2_valid = 1; q2_tag = 4'd1;
    #1;
    chk("io_q1_hit", q1_hit, 1);
    chk("io_q1_data", q1_data, 32'h22);
    chk("io_q2_miss", q2_hit, 0);
    chk("io_q2_data0", q2_data, 0);
    clr();
    wb(0, 4'd0, 32'h11, 0, 0);
    tick();
    clr();
    chk("io_wb_edge_no_commit", commit_valid, 0);
    tick();
    chk("io_c0_valid", commit_valid, 1);
    chk("io_c0_tag", commit_tag, 0);
    chk("io_c0_data", commit_data, 32'h11);
    chk("io_c0_dest", commit_dest, 5);
    chk("io_c0_count", count, 2);
    tick();
    chk("io_stall", commit_valid, 0);
    wb(1, 4'd1, 32'h33, 0, 0);
    tick();
    clr();
    chk("io_stall2", commit_valid, 0);
    tick();
    chk("io_c1_valid", commit_valid, 1);
    chk("io_c1_data", commit_data, 32'h33);
    chk("io_c1_dest", commit_dest, 6);
    tick();
    chk("io_c2_valid", commit_valid, 1);
    chk("io_c2_tag", commit_tag, 2);
    chk("io_c2_data", commit_data, 32'h22);
    chk("io_c2_count", count, 0);
    tick();
    chk("io_idle", commit_valid, 0);

    // Writeback priority and bypass
    do_reset();
    for (int i = 0; i < 5; i++) alloc(5'(i + 1), 0, 0, 0);
    wb(0, 4'd3, 32'hA, 0, 0);
    wb(2, 4'd3, 32'hB, 0, 0);
    wb(1, 4'd4, 32'hC, 0, 0);
    q1_valid = 1; q1_tag = 4'd4; q2_valid = 1; q2_tag = 4'd3;
    #1;
    chk("byp_q1_hit", q1_hit, 1);
    chk("byp_q1_data", q1_data, 32'hC);
    chk("byp_q2_prio", q2_data, 32'hA);
    tick();
    clr();
    q2_valid = 1; q2_tag = 4'd3; q1_valid = 1; q1_tag = 4'd9;
    #1;
    chk("prio_stored_hit", q2_hit, 1);
    chk("prio_stored_data", q2_data, 32'hA);
    chk("unocc_miss", q1_hit, 0);
    chk("unocc_data0", q1_data, 0);
    clr();

    // Mispredict flush
    do_reset();
    alloc(5'd1, 0, 1, 0);
    chk("mem_head_valid", mem_head_valid, 1);
    chk("mem_head_tag", mem_head_tag, 0);
    alloc(5'd0, 0, 0, 1);
    for (int i = 2; i < 6; i++) alloc(5'(i), 0, 0, 0);
    chk("br_count6", count, 6);
    wb(0, 4'd0, 32'h50, 0, 0);
    wb(1, 4'd1, 32'h0, 1, 32'h1000);
    tick();
    clr();
    chk("br_no_flush_yet", flush, 0);
    tick();
    chk("br_c0_valid", commit_valid, 1);
    chk("br_c0_data", commit_data, 32'h50);
    chk("br_c0_flush", flush, 0);
    chk("br_c0_count", count, 5);
    alloc_valid = 1; alloc_dest = 5'd9;
    wb(0, 4'd2, 32'h99, 0, 0);
    tick();
    clr();
    chk("fl_flush", flush, 1);
    chk("fl_redirect", redirect_pc, 32'h1000);
    chk("fl_count", count, 0);
    chk("fl_alloc_tag", alloc_tag, 0);
    chk("fl_commit_silent", commit_valid, 0);
    chk("fl_mem_head", mem_head_valid, 0);
    q1_valid = 1; q1_tag = 4'd2;
    #1;
    chk("fl_wb_lost", q1_hit, 0);
    clr();
    tick();
    chk("fl_pulse_end", flush, 0);
    chk("fl_count_after", count, 0);

    // rdy freeze
    do_reset();
    alloc(5'd9, 0, 0, 0);
    alloc(5'd10, 0, 0, 0);
    wb(0, 4'd0, 32'h77, 0, 0);
    tick();
    clr();
    tick();
    chk("rdy_c0_valid", commit_valid, 1);
    chk("rdy_c0_data", commit_data, 32'h77);
    rdy = 0;
    alloc_valid = 1; alloc_dest = 5'd11;
    wb(0, 4'd1, 32'h88, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("frz_commit_held", commit_valid, 1);
      chk("frz_count", count, 1);
      chk("frz_tail", alloc_tag, 2);
    end
    rdy = 1;
    clr();
    tick();
    chk("res_no_commit", commit_valid, 0);
    chk("res_count", count, 1);
    wb(0, 4'd1, 32'h88, 0, 0);
    tick();
    clr();
    tick();
    chk("res_c1_valid", commit_valid, 1);
    chk("res_c1_data", commit_data, 32'h88);
    chk("res_c1_dest", commit_dest, 10);

    // Asynchronous reset mid-stream
    do_reset();
    for (int i = 0; i < 7; i++) alloc(5'(i + 1), 0, 0, 0);
    chk("ar_count7", count, 7);
    wb(0, 4'd0, 32'h5, 0, 0);
    tick();
    clr();
    tick();
    chk("ar_pre_commit", commit_valid, 1);
    #3;
    rst = 1;
    #1;
    chk("ar_count", count, 0);
    chk("ar_commit_valid", commit_valid, 0);
    chk("ar_commit_data", commit_data, 0);
    chk("ar_alloc_tag", alloc_tag, 0);
    chk("ar_full", full, 0);
    #1;
    rst = 0;
    tick();
    tick();
    chk("ar_no_commit", commit_valid, 0);
    chk("ar_count_after", count, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
